wb_regfile_arbiter: RTL and testbench
=====================================

// Module: wb_regfile_arbiter
// PURPOSE
//  Shares the register file's single write port between the pipeline writeback stage and the debug/loader unit.
//  It sits between the WB stage outputs (datatoregfile/weregfile) and the regfile write port.
//  The pipeline has priority; a starving debug request forces a one-cycle pipeline stall to get its write in.
//  It also suppresses writes to $0 and registers the write port.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register address width
//  STARVE_MAX  8   consecutive denied debug cycles before a forced stall (>=1)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  wb_we      in   1       WB stage write enable (weregfile)
//  wb_addr    in   ADDR_W  WB destination register
//  wb_data    in   DATA_W  WB write data (datatoregfile)
//  dbg_req    in   1       debug write request, level, held until dbg_ack
//  dbg_addr   in   ADDR_W  debug destination register, stable while dbg_req=1
//  dbg_data   in   DATA_W  debug write data, stable while dbg_req=1
//  dbg_ack    out  1       one-cycle pulse: debug write committed this cycle
//  pipe_stall out  1       freezes IF..WB for one cycle (forced debug slot)
//  rf_we      out  1       regfile write enable (registered)
//  rf_addr    out  ADDR_W  regfile write address (registered)
//  rf_data    out  DATA_W  regfile write data (registered)
// BEHAVIOUR
//  Reset: rf_we=0, rf_addr=0, rf_data=0, dbg_ack=0, pipe_stall=0, state=IDLE, starve count=0.
//    Reset is asynchronous; a request pending at reset gets no ack and is re-arbitrated from IDLE.
//  Latency: rf_* show the winning write on the edge after its inputs are sampled (1 cycle).
//    The forwarding unit sources from rf_*.
//  $0 rule: any winning write with addr==0 gives rf_we=0. A debug write to $0 is still acked.
//  States:
//    IDLE:
//      - wb_we=1 -> pipeline write wins.
//      - else dbg_req=1 -> debug write wins; dbg_ack=1 next cycle.
//      - dbg_req=1 and wb_we=1 -> DBG_WAIT with count=1.
//    DBG_WAIT:
//      - wb_we=1 -> pipeline write, count++.
//      - wb_we=0 -> debug write wins, ack, -> IDLE.
//      - count reaching STARVE_MAX -> STALL; pipe_stall=1 next cycle.
//    STALL (pipe_stall=1 for exactly one cycle):
//      - debug write wins unconditionally; wb_* ignored.
//      - The frozen WB stage holds its inputs and re-presents them next cycle.
//      - dbg_ack=1, pipe_stall=0, -> IDLE.
//  dbg_req is ignored in the cycle dbg_ack=1, so one request never gets two grants.
//  dbg_req dropped before ack (violation): -> IDLE, count=0, no write, no ack.
//    Applies in STALL too; pipe_stall still falls.
//  STARVE_MAX=1: the first denied cycle goes straight to STALL.
//  No write winner in a cycle: rf_we=0; rf_addr/rf_data hold their last value.
//  Counter width: $clog2(STARVE_MAX+1); saturates, never wraps.
// STRUCTURE
//  Shared package mips_pkg: state encoding (IDLE/DBG_WAIT/STALL), REG_ZERO=5'd0, DATA_W/ADDR_W defaults.
//  One sub-module: wb_starve_timer.
//    Inputs: clear, inc. Output: expired.
//    Counts denied cycles, saturates at STARVE_MAX.
//  The FSM and the registered write-port mux stay in this module.
// TESTING
//  1 wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, no dbg
//      -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; pipe_stall=0.
//  2 wb_we=0, dbg_req=1, dbg_addr=3, dbg_data=0x12
//      -> next cycle rf_we=1, rf_addr=3, rf_data=0x12, dbg_ack=1 for one cycle, no stall.
//  3 wb_we=1 held every cycle, dbg_req=1 (addr 7, data 0xA5)
//      -> 8 pipeline writes, then pipe_stall=1 for one cycle.
//      -> Next cycle rf_addr=7, rf_data=0xA5, dbg_ack=1; the frozen WB write lands the cycle after.
//  4 wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF -> rf_we=0.
//    Then dbg write to $0 -> dbg_ack=1 with rf_we=0.
//  5 rst_n low during STALL
//      -> all outputs 0 immediately (async), no ack.
//      -> After release with dbg_req still high and wb_we=0, ack arrives on the 1st post-reset edge.
//  6 dbg_req dropped while in DBG_WAIT (count=4) -> IDLE, no ack.
//    A new request then restarts the count from 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the regfile write-port arbiter: state and winner
// encodings, default widths and the hard-wired zero register.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DBG_WAIT = 2'd1,
        ST_STALL    = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_DBG  = 2'd2
    } win_sel_e;

    // Writes to the zero register are dropped at the port, never stored.
    function automatic logic is_reg_zero(input logic [ADDR_W_DEF-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_regfile_arbiter_if.sv
// Bus bundle between the WB stage / debug loader (master) and the regfile
// write-port arbiter (slave).
interface wb_regfile_arbiter_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    modport master (
        output wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data,
        input  dbg_ack, pipe_stall, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data,
        output dbg_ack, pipe_stall, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/wb_starve_timer.sv
// Starvation timer for denied debug requests: down-counter loaded with
// STARVE_MAX, holds at zero, flags the increment that reaches the limit.
module wb_starve_timer #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] remain_d;

    always_comb begin
        remain_d = remain_q;
        if (clear) begin
            remain_d = LOAD;
        end else if (inc && (remain_q != '0)) begin
            remain_d = remain_q - ONE;
        end
    end

    // Independent of clear so the FSM can derive clear from its next state.
    assign expired = inc && (remain_q <= ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= LOAD;
        end else begin
            remain_q <= remain_d;
        end
    end
endmodule

// File: rtl/wb_regfile_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, a starving
// debug write forces a one-cycle pipeline stall; write port is registered.
//
// state       | meaning
// ST_IDLE     | no debug request outstanding, pipeline owns the port
// ST_DBG_WAIT | debug request pending, denied while the pipeline writes
// ST_STALL    | pipe_stall high this cycle, debug write wins unconditionally
module wb_regfile_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_regfile_arbiter_if.slave   bus
);
    arb_state_e        state_q;
    arb_state_e        state_d;
    win_sel_e          win_sel;
    logic              dbg_live;
    logic              ack_d;
    logic              tmr_inc;
    logic              tmr_clear;
    logic              tmr_expired;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              dbg_ack_q;
    logic              pipe_stall_q;

    // The request is still high while its ack is shown; masking it here keeps
    // one request from collecting a second grant.
    assign dbg_live = bus.dbg_req && !dbg_ack_q;

    wb_starve_timer #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wb_we && dbg_live) begin
                    state_d = tmr_expired ? ST_STALL : ST_DBG_WAIT;
                end
            end
            ST_DBG_WAIT: begin
                if (!dbg_live) begin
                    state_d = ST_IDLE;
                end else if (bus.wb_we) begin
                    state_d = tmr_expired ? ST_STALL : ST_DBG_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_sel = SEL_NONE;
        ack_d   = 1'b0;
        tmr_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.wb_we) begin
                    win_sel = SEL_PIPE;
                    tmr_inc = dbg_live;
                end else if (dbg_live) begin
                    win_sel = SEL_DBG;
                    ack_d   = 1'b1;
                end
            end
            ST_DBG_WAIT: begin
                if (!dbg_live) begin
                    win_sel = bus.wb_we ? SEL_PIPE : SEL_NONE;
                end else if (bus.wb_we) begin
                    win_sel = SEL_PIPE;
                    tmr_inc = 1'b1;
                end else begin
                    win_sel = SEL_DBG;
                    ack_d   = 1'b1;
                end
            end
            ST_STALL: begin
                if (dbg_live) begin
                    win_sel = SEL_DBG;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                win_sel = SEL_NONE;
            end
        endcase
    end

    // Every path back to IDLE restarts the starvation count.
    assign tmr_clear = (state_d == ST_IDLE);

    assign win_addr = (win_sel == SEL_DBG) ? bus.dbg_addr : bus.wb_addr;
    assign win_data = (win_sel == SEL_DBG) ? bus.dbg_data : bus.wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            dbg_ack_q    <= 1'b0;
            pipe_stall_q <= 1'b0;
        end else begin
            rf_we_q      <= (win_sel != SEL_NONE) && (win_addr != ADDR_W'(REG_ZERO));
            dbg_ack_q    <= ack_d;
            pipe_stall_q <= (state_d == ST_STALL);
            if (win_sel != SEL_NONE) begin
                rf_addr_q <= win_addr;
                rf_data_q <= win_data;
            end
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_addr    = rf_addr_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.pipe_stall = pipe_stall_q;
endmodule

// File: tb/tb_wb_regfile_arbiter.sv
// Scoreboard bench for wb_regfile_arbiter: directed steps queue expected
// output events, a negedge monitor pops and compares them.
module tb_wb_regfile_arbiter;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ack;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];

    wb_regfile_arbiter_if bus ();

    wb_regfile_arbiter #(.STARVE_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.rf_we || bus.dbg_ack || bus.pipe_stall)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: we=%0b addr=%0d data=0x%0h ack=%0b stall=%0b at cycle %0d, expected none",
                         bus.rf_we, bus.rf_addr, bus.rf_data, bus.dbg_ack, bus.pipe_stall, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
                if (e.we) begin
                    chk("rf_addr", {27'd0, bus.rf_addr}, {27'd0, e.addr});
                    chk("rf_data", bus.rf_data, e.data);
                end
                chk("dbg_ack", {31'd0, bus.dbg_ack}, {31'd0, e.ack});
                chk("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, e.stall});
            end
        end
    end

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rq, input logic [4:0] ra, input logic [31:0] rd,
                        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                        input logic eack, input logic estall);
        exp_t e;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.dbg_req  = rq;
        bus.dbg_addr = ra;
        bus.dbg_data = rd;
        if (ewe || eack || estall) begin
            e.cyc   = cyc + 1;
            e.we    = ewe;
            e.addr  = ea;
            e.data  = ed;
            e.ack   = eack;
            e.stall = estall;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_we"}, {31'd0, bus.rf_we}, 32'd0);
        chk({tag, "_rf_addr"}, {27'd0, bus.rf_addr}, 32'd0);
        chk({tag, "_rf_data"}, bus.rf_data, 32'd0);
        chk({tag, "_dbg_ack"}, {31'd0, bus.dbg_ack}, 32'd0);
        chk({tag, "_pipe_stall"}, {31'd0, bus.pipe_stall}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.dbg_req = 0; bus.dbg_addr = 0; bus.dbg_data = 0;
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 1: plain pipeline write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        idle();

        // 2: debug write with idle pipeline; request held through the ack cycle
        step(0, 0, 0, 1, 3, 32'h12, 1, 3, 32'h12, 1, 0);
        step(0, 0, 0, 1, 3, 32'h12, 0, 0, 0, 0, 0);
        idle();

        // 3: starvation -> forced stall, then frozen WB write lands
        for (int i = 1; i <= 8; i++)
            step(1, 9, 32'(i), 1, 7, 32'hA5, 1, 9, 32'(i), 0, (i == 8));
        step(1, 9, 32'd9, 1, 7, 32'hA5, 1, 7, 32'hA5, 1, 0);
        step(1, 9, 32'd9, 1, 7, 32'hA5, 1, 9, 32'd9, 0, 0);
        idle();

        // 4: $0 suppression for both sources; debug still acked
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0);
        idle();

        // 5: async reset during STALL, request survives and is re-arbitrated
        for (int i = 1; i <= 8; i++)
            step(1, 10, 32'h100 + 32'(i), 1, 11, 32'hBB, 1, 10, 32'h100 + 32'(i), 0, (i == 8));
        @(negedge clk);
        #1;
        bus.wb_we = 0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, 1, 11, 32'hBB, 1, 11, 32'hBB, 1, 0);
        step(0, 0, 0, 1, 11, 32'hBB, 0, 0, 0, 0, 0);
        idle();

        // 6: request dropped in DBG_WAIT at count 4, new request restarts count
        for (int i = 1; i <= 4; i++)
            step(1, 12, 32'h200 + 32'(i), 1, 13, 32'hCC, 1, 12, 32'h200 + 32'(i), 0, 0);
        step(1, 12, 32'h205, 0, 0, 0, 1, 12, 32'h205, 0, 0);
        for (int i = 1; i <= 8; i++)
            step(1, 12, 32'h300 + 32'(i), 1, 14, 32'hDD, 1, 12, 32'h300 + 32'(i), 0, (i == 8));
        step(1, 12, 32'h309, 1, 14, 32'hDD, 1, 14, 32'hDD, 1, 0);
        step(1, 12, 32'h309, 1, 14, 32'hDD, 1, 12, 32'h309, 0, 0);
        idle();

        repeat (3) @(posedge clk);
        #2;
        chk("pending_expected_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
